// File: rtl/wb_mem_bridge.sv
// wb_mem_bridge: turns the core's single-cycle memory port into Wishbone B4 classic master cycles.
// Stalls the pipeline while a bus cycle is open and holds read data until the pipeline releases it.
module wb_mem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [SEL_W-1:0]  cpu_sel_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    output logic              bus_err_o,
    input  logic              wb_ack_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic [DATA_W-1:0] wb_dat_o
);

    localparam int TMO_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY       = 2'd1,
        WAIT_STALL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              cyc_q, cyc_d;
    logic              we_q, we_d;
    logic              bus_err_q, bus_err_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [DATA_W-1:0] rd_buf_q, rd_buf_d;

    logic req_ok;
    logic stalled;
    logic timeout_hit;

    assign req_ok      = cpu_ce_i & ~flush_i;
    assign stalled     = |stall_i;
    assign timeout_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            tmo_cnt_q <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            bus_err_q <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            rd_buf_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            bus_err_q <= bus_err_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            rd_buf_q  <= rd_buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        bus_err_d = 1'b0;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rd_buf_d  = rd_buf_q;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d   = BUSY;
                    cyc_d     = 1'b1;
                    we_d      = cpu_we_i;
                    adr_d     = cpu_addr_i;
                    sel_d     = cpu_sel_i;
                    dat_d     = cpu_data_i;
                    tmo_cnt_d = '0;
                end
            end
            BUSY: begin
                // Flush outranks a same-cycle ack: the returned data is dropped.
                if (flush_i) begin
                    state_d  = IDLE;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    rd_buf_d = '0;
                end else if (wb_ack_i) begin
                    state_d = stalled ? WAIT_STALL : IDLE;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (timeout_hit) begin
                        state_d   = WAIT_STALL;
                        cyc_d     = 1'b0;
                        we_d      = 1'b0;
                        bus_err_d = 1'b1;
                        rd_buf_d  = '0;
                    end
                end
            end
            WAIT_STALL: begin
                if (!stalled || flush_i) begin
                    state_d = IDLE;
                end
                if (flush_i) begin
                    rd_buf_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stallreq_o = 1'b0;
        cpu_data_o = '0;
        case (state_q)
            IDLE:       stallreq_o = req_ok;
            BUSY: begin
                stallreq_o = ~wb_ack_i;
                if (wb_ack_i) begin
                    cpu_data_o = wb_dat_i;
                end
            end
            WAIT_STALL: cpu_data_o = rd_buf_q;
            default: ;
        endcase
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_dat_o  = dat_q;
    assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_wb_mem_bridge.sv
// Bench for wb_mem_bridge: transaction-level reference model compared every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_wb_mem_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic        ack = 1'b0;
    logic [31:0] rdat = '0;

    logic [31:0] cpu_data_o;
    logic        stallreq_o, bus_err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;

    int n_total = 0;
    int n_pass  = 0;
    int cyc_hi  = 0;
    int err_hi  = 0;

    wb_mem_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush),
        .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_sel_i(sel),
        .cpu_data_i(wdat), .cpu_data_o(cpu_data_o), .stallreq_o(stallreq_o),
        .bus_err_o(bus_err_o), .wb_ack_i(ack), .wb_dat_i(rdat),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one outstanding transfer plus "served, waiting for pipeline release".
    bit          m_open, m_hold, m_we, m_err;
    int          m_waited;
    logic [31:0] m_buf, m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        e_stall;
    logic [31:0] e_data;

    always @(negedge clk) begin
        if (!rst) begin
            m_open = 0; m_hold = 0; m_we = 0; m_err = 0; m_waited = 0;
            m_buf = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        end
        if (m_open) begin
            e_stall = !ack;
            e_data  = ack ? rdat : 32'h0;
        end else if (m_hold) begin
            e_stall = 1'b0;
            e_data  = m_buf;
        end else begin
            e_stall = ce && !flush;
            e_data  = 32'h0;
        end
        chk("m_cyc", wb_cyc_o, m_open);
        chk("m_stb", wb_stb_o, m_open);
        chk("m_we", wb_we_o, m_open && m_we);
        chk("m_adr", wb_adr_o, m_adr);
        chk("m_sel", wb_sel_o, m_sel);
        chk("m_wdat", wb_dat_o, m_dat);
        chk("m_err", bus_err_o, m_err);
        chk("m_stallreq", stallreq_o, e_stall);
        chk("m_cpu_data", cpu_data_o, e_data);
        if (wb_cyc_o) cyc_hi++;
        if (bus_err_o) err_hi++;
        if (rst) begin
            m_err = 0;
            if (m_open) begin
                if (flush) begin
                    m_open = 0; m_buf = '0;
                end else if (ack) begin
                    m_open = 0;
                    if (!m_we) m_buf = rdat;
                    m_hold = (stall != 0);
                end else begin
                    m_waited++;
                    if (m_waited == TMO) begin
                        m_open = 0; m_err = 1; m_buf = '0; m_hold = 1;
                    end
                end
            end else if (m_hold) begin
                if (flush) m_buf = '0;
                if (stall == 0 || flush) m_hold = 0;
            end else if (ce && !flush) begin
                m_open = 1; m_we = we; m_adr = addr; m_sel = sel; m_dat = wdat;
                m_waited = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_data", cpu_data_o, 0);
        tick();
        rst = 1'b1;
        tick();

        // Read, zero-wait slave
        ce = 1; we = 0; addr = 32'h40; sel = 4'hF;
        @(negedge clk);
        chk("t1_stallreq_req", stallreq_o, 1);
        tick();
        ack = 1; rdat = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_fwd", cpu_data_o, 32'hDEADBEEF);
        chk("t1_stallreq_ack", stallreq_o, 0);
        tick();
        ce = 0; ack = 0; rdat = 0;
        @(negedge clk);
        chk("t1_idle_cyc", wb_cyc_o, 0);
        tick();

        // Write with three wait states
        cyc_hi = 0;
        ce = 1; we = 1; addr = 32'h100; sel = 4'b0011; wdat = 32'h1234; rdat = 32'hFFFFFFFF;
        tick();
        repeat (3) tick();
        ack = 1;
        @(negedge clk);
        chk("t2_adr", wb_adr_o, 32'h100);
        chk("t2_sel", wb_sel_o, 4'b0011);
        chk("t2_wdat", wb_dat_o, 32'h1234);
        chk("t2_we", wb_we_o, 1);
        tick();
        ce = 0; we = 0; ack = 0; rdat = 0; wdat = 0;
        tick();
        chk("t2_cyc_len", cyc_hi, 4);

        // Read acked while the pipeline is stalled elsewhere
        ce = 1; addr = 32'h200; sel = 4'hF;
        tick();
        ack = 1; rdat = 32'hCAFE0001; stall = 6'b000011;
        tick();
        ack = 0; rdat = 0;
        @(negedge clk);
        chk("t3_hold_data1", cpu_data_o, 32'hCAFE0001);
        chk("t3_hold_stallreq", stallreq_o, 0);
        tick();
        @(negedge clk);
        chk("t3_hold_data2", cpu_data_o, 32'hCAFE0001);
        tick();
        stall = 0;
        @(negedge clk);
        chk("t3_hold_data3", cpu_data_o, 32'hCAFE0001);
        tick();
        ce = 0;
        @(negedge clk);
        chk("t3_idle_data", cpu_data_o, 0);
        tick();

        // Flush colliding with ack in the second bus cycle
        ce = 1; addr = 32'h300;
        tick();
        tick();
        flush = 1; ack = 1; rdat = 32'h55555555;
        tick();
        flush = 0; ack = 0; rdat = 0; ce = 0;
        @(negedge clk);
        chk("t4_cyc_drop", wb_cyc_o, 0);
        chk("t4_stb_drop", wb_stb_o, 0);
        tick();
        ce = 1; we = 1; addr = 32'h304; wdat = 32'hA5;
        tick();
        ack = 1; stall = 6'b000001;
        tick();
        ack = 0;
        @(negedge clk);
        chk("t4_rdbuf_cleared", cpu_data_o, 0);
        tick();
        stall = 0; ce = 0; we = 0; wdat = 0;
        tick();
        tick();

        // Slave never answers: timeout abort
        cyc_hi = 0; err_hi = 0;
        ce = 1; addr = 32'h400;
        tick();
        repeat (TMO) tick();
        ce = 0;
        @(negedge clk);
        chk("t5_err", bus_err_o, 1);
        chk("t5_data", cpu_data_o, 0);
        chk("t5_stallreq", stallreq_o, 0);
        tick();
        tick();
        chk("t5_cyc_len", cyc_hi, TMO);
        chk("t5_err_pulses", err_hi, 1);

        // Asynchronous reset in the middle of a bus cycle
        ce = 1; addr = 32'h500;
        tick();
        #2 rst = 0;
        #1;
        chk("t6_cyc_async", wb_cyc_o, 0);
        chk("t6_stb_async", wb_stb_o, 0);
        chk("t6_adr_async", wb_adr_o, 0);
        chk("t6_err_async", bus_err_o, 0);
        tick();
        ce = 0; rst = 1;
        tick();
        ce = 1; addr = 32'h600;
        tick();
        ack = 1; rdat = 32'h0BADF00D;
        @(negedge clk);
        chk("t6_adr_new", wb_adr_o, 32'h600);
        chk("t6_fwd_new", cpu_data_o, 32'h0BADF00D);
        tick();
        ce = 0; ack = 0; rdat = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
